// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - game-side bundle between the renderer and the score display
// master = game/renderer side, slave = score_display.
interface score_display_if;
  logic       pass;
  logic       new_game;
  logic [7:0] score_bcd;
  logic [7:0] best_bcd;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output pass, new_game,
    input  score_bcd, best_bcd, an, seg, dp
  );

  modport slave (
    input  pass, new_game,
    output score_bcd, best_bcd, an, seg, dp
  );
endinterface

// File: rtl/score_display.sv
// rtl/score_display.sv - BCD pipe score with best-score register and 4-digit multiplexed 7-segment drive
// Right digit pair shows the current score, left pair the best score.
module score_display #(
  parameter int REFRESH_BITS = 17,
  parameter int SCORE_MAX    = 99
) (
  input  logic           clk,
  input  logic           rst,
  score_display_if.slave bus
);

  localparam logic [7:0] MAX_BCD = 8'(((SCORE_MAX / 10) * 16) + (SCORE_MAX % 10));

  logic                    p1_q, p2_q, p3_q;
  logic                    inc;
  logic [7:0]              score_q, score_d;
  logic [7:0]              best_q, best_d;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              idx;
  logic [3:0]              digit;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // pass is asynchronous to clk; count only the rising edge after synchronisation
  assign inc = p2_q & ~p3_q;

  always_comb begin
    score_d = score_q;
    if (bus.new_game) begin
      score_d = 8'h00;
    end else if (inc && (score_q < MAX_BCD)) begin
      if (score_q[3:0] == 4'd9) begin
        score_d = {score_q[7:4] + 4'd1, 4'd0};
      end else begin
        score_d = {score_q[7:4], score_q[3:0] + 4'd1};
      end
    end
  end

  // Tens in the upper nibble make a plain unsigned compare a valid BCD compare
  assign best_d = (score_q > best_q) ? score_q : best_q;

  assign idx = cnt_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0:    digit = score_q[3:0];
      2'd1:    digit = score_q[7:4];
      2'd2:    digit = best_q[3:0];
      default: digit = best_q[7:4];
    endcase
  end

  // Odd idx values are tens digits, which are blanked when zero
  assign seg_d = (idx[0] && (digit == 4'd0)) ? 7'b1111111 : seg_decode(digit);
  assign an_d  = ~(4'b0001 << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      p3_q    <= 1'b0;
      score_q <= 8'h00;
      best_q  <= 8'h00;
      cnt_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      p1_q    <= bus.pass;
      p2_q    <= p1_q;
      p3_q    <= p2_q;
      score_q <= score_d;
      best_q  <= best_d;
      cnt_q   <= cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.best_bcd  = best_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display against a decimal reference model
// Stimulus pushes the expected post-edge outputs; the monitor pops and compares after each edge.
module tb_score_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_display_if bus();

  score_display #(.REFRESH_BITS(4), .SCORE_MAX(99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] best;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain decimal score/best, refresh position, last three pass samples
  int   m_score = 0;
  int   m_best  = 0;
  int   m_cnt   = 0;
  bit   h0 = 0, h1 = 0, h2 = 0;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit p, input bit ng, input bit r);
    exp_t e;
    int   pos, digit, old_score;
    bit   inc;
    @(negedge clk);
    bus.pass     = p;
    bus.new_game = ng;
    rst          = r;
    if (r) begin
      m_score = 0;
      m_best  = 0;
      m_cnt   = 0;
      e.an    = 4'b1111;
      e.seg   = 7'b1111111;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      pos   = m_cnt / 4;
      e.an  = 4'b1111;
      e.an[pos] = 1'b0;
      case (pos)
        0:       digit = m_score % 10;
        1:       digit = m_score / 10;
        2:       digit = m_best % 10;
        default: digit = m_best / 10;
      endcase
      e.seg = ((pos % 2 == 1) && (digit == 0)) ? 7'b1111111 : seg_tab[digit];
      inc       = h1 && !h2;
      old_score = m_score;
      if (ng) m_score = 0;
      else if (inc && m_score < 99) m_score = m_score + 1;
      if (old_score > m_best) m_best = old_score;
      m_cnt = (m_cnt + 1) % 16;
      h2 = h1; h1 = h0; h0 = p;
    end
    e.score = to_bcd(m_score);
    e.best  = to_bcd(m_best);
    sbq.push_back(e);
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0, 1'b0);
    repeat (lo) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("score_bcd", bus.score_bcd, e.score);
        check("best_bcd", bus.best_bcd, e.best);
        check("an", {4'b0, bus.an}, {4'b0, e.an});
        check("seg", {1'b0, bus.seg}, {1'b0, e.seg});
        check("dp", {7'b0, bus.dp}, 8'h01);
      end
    end
  end

  initial begin : stimulus
    bit p;
    int budget;
    rst          = 1'b1;
    bus.pass     = 1'b0;
    bus.new_game = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    // single long pass counts once
    repeat (5) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    // carry 09 -> 10, then run into saturation
    repeat (10) pulse(3, 3);
    repeat (91) pulse(3, 3);
    // best survives new_game
    step(0, 0, 1);
    repeat (12) pulse(3, 3);
    step(0, 1, 0);
    repeat (3) pulse(3, 3);
    // new_game coincident with inc drops the increment
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    // reset mid-scan
    repeat (6) step(0, 0, 0);
    step(0, 0, 1);
    repeat (20) step(0, 0, 0);
    p = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) p = ~p;
      step(p, ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) == 0));
    end
    step(0, 0, 0);
    budget = 20;
    while (sbq.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the game renderer's `pass` flag.
- Counts each pipe passed as a 2-digit BCD score and keeps a best-score register.
- Drives a 4-digit multiplexed common-anode 7-segment display on the board: right pair shows the current score, left pair shows the best.
- Same clock domain as the VGA/game logic.

Parameters:
- REFRESH_BITS, 17, width of the digit-refresh counter; each digit is lit for 2^(REFRESH_BITS-2) clk cycles. Benches use 4.
- SCORE_MAX, 99, saturation value of the score; BCD, must be at most 99.

Ports:
- clk  in  1  system clock; the same clk that feeds the renderer's divider.
- rst  in  1  synchronous, active-high reset; clears everything, including best.
- pass  in  1  level from the renderer; high for one or more cycles per pipe passed. Not assumed aligned to clk.
- new_game  in  1  1-cycle pulse; clears score only.
- score_bcd  out  8  current score, [7:4]=tens, [3:0]=ones.
- best_bcd  out  8  best score, same format.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - score_bcd=0, best_bcd=0, refresh counter=0, pass synchroniser/edge regs=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- pass input path:
  - 2-flop synchroniser (p1, p2), then edge register p3.
  - inc = p2 & ~p3.
  - Latency: score changes on the 3rd rising edge at which pass is sampled high; pass must stay high for at least 2 cycles.
  - A pass held high for N cycles counts exactly once.
  - Re-arming requires pass low for at least 1 synchronised cycle.
- Score update, in priority order:
  - rst: clear score.
  - new_game: score <= 0. Any coincident inc is dropped and the synchroniser keeps running; a pass edge arriving during the pulse is lost.
  - inc with score < SCORE_MAX: BCD increment. Ones 9 -> 0 carries into tens (09 -> 10).
  - inc with score == SCORE_MAX: hold (saturate); no wrap to 00.
- Best update:
  - Each cycle, if score > best (BCD compare, tens first), best <= score.
  - This gives a 1-cycle lag after score changes.
  - new_game never touches best.
- Refresh:
  - REFRESH_BITS-wide free-running counter; wraps from all-ones to 0.
  - idx = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - idx 0 = score ones, 1 = score tens, 2 = best ones, 3 = best tens.
- Digit outputs:
  - an and seg are registered: they reflect idx and the BCD values of the previous cycle.
  - an = ~(4'b0001 << idx); exactly one digit is low out of reset.
  - The first cycle after reset deasserts gives an=4'b1110.
- Leading-zero blanking: when a tens digit is 0, seg=7'b1111111 for that digit; ones digits always display.
- Segment encoding (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD nibble displays blank. This is unreachable, but the decoder must be total.
- Reset mid-display: outputs go to the all-off reset values on the reset edge; scanning restarts from idx 0.

Test Plan:
- Reset, then 1 idle cycle -> score_bcd=8'h00, best_bcd=8'h00, an=4'b1110, seg=7'b1000000 (ones "0"). Tens digits blank while their idx is active.
- pass high for 5 cycles, then low -> score_bcd=8'h01 exactly 3 edges after the first high sample; stays 01. best_bcd=8'h01 one cycle later.
- 10 separated pass pulses (3 high / 3 low) -> score goes 09 -> 10 (carry). When idx=1 is active, seg=7'b1111001 ("1").
- Drive score to 99, then 3 more pulses -> score_bcd stays 8'h99; best_bcd=8'h99.
- From score 12 / best 12: new_game, then 3 pulses -> score_bcd=8'h03, best_bcd=8'h12. Also assert new_game on the same cycle as inc -> score 00, increment dropped.
- REFRESH_BITS=4, run 16 cycles -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles and lagging the counter by 1 cycle. Assert rst mid-scan -> an=1111, seg=1111111 on the next edge.
